pencode_rr: RTL and testbench

PENCODE_RR -- requirements
Module: pencode_rr

---
 rtl/pencode_rr_if.sv | 18 +
 rtl/pencode_rr.sv | 91 +++++++++
 tb/tb_pencode_rr.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pencode_rr_if.sv
// Request/grant bundle for pencode_rr: requester side drives en/Din/ack,
// encoder side returns the held grant and idle status.
interface pencode_rr_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] Din;
  logic         ack;
  logic         valid;
  logic [W-1:0] Dout;
  logic [N-1:0] gnt;
  logic         idle;

  modport master (output en, Din, ack, input  valid, Dout, gnt, idle);
  modport slave  (input  en, Din, ack, output valid, Dout, gnt, idle);
endinterface

// File: rtl/pencode_rr.sv
// Priority encoder / arbiter with a latched grant held until ack.
// RR=0: highest set index wins; RR=1: round-robin search starting at ptr.
module pencode_rr #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  pencode_rr_if.slave   b
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state, state_n;
  logic         valid_q, valid_n;
  logic [W-1:0] dout_q, dout_n;
  logic [N-1:0] gnt_q, gnt_n;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] win, idx;
  logic         found;

  // Winner select. Index arithmetic is W bits wide, so ptr+k wraps mod N.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (RR != 0) begin
      for (int k = 0; k < N; k++) begin
        idx = ptr + W'(k);
        if (!found && b.Din[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (b.Din[k]) win = W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      dout_q  <= '0;
      gnt_q   <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      valid_q <= valid_n;
      dout_q  <= dout_n;
      gnt_q   <= gnt_n;
      ptr     <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = valid_q;
    dout_n  = dout_q;
    gnt_n   = gnt_q;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (b.en && (|b.Din)) begin
          state_n = GRANT;
          valid_n = 1'b1;
          dout_n  = win;
          gnt_n   = N'(1) << win;
        end
      end
      GRANT: begin
        // Grant is latched; only ack releases it, and pointer moves only here.
        if (valid_q && b.ack) begin
          state_n = IDLE;
          valid_n = 1'b0;
          dout_n  = '0;
          gnt_n   = '0;
          if (RR != 0) ptr_n = dout_q + W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign b.valid = valid_q;
  assign b.Dout  = dout_q;
  assign b.gnt   = gnt_q;
  assign b.idle  = (state == IDLE);
endmodule

// File: tb/tb_pencode_rr.sv
// Directed bench for pencode_rr: one fixed-priority and one round-robin
// instance (N=8) sharing clock and reset.
module tb_pencode_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pencode_rr_if #(.N(8)) fp_if ();
  pencode_rr_if #(.N(8)) rr_if ();

  pencode_rr #(.N(8), .RR(0)) u_fp (.clk(clk), .rst_n(rst_n), .b(fp_if));
  pencode_rr #(.N(8), .RR(1)) u_rr (.clk(clk), .rst_n(rst_n), .b(rr_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fp_if.en = 1'b0; fp_if.Din = '0; fp_if.ack = 1'b0;
    rr_if.en = 1'b0; rr_if.Din = '0; rr_if.ack = 1'b0;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_fp: got v=%0b i=%0b d=%0d g=%h want v=0 i=1 d=0 g=00",
               fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt);
    end
    n_cmp++;
    if ({rr_if.valid, rr_if.idle, rr_if.Dout, rr_if.gnt} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_rr: got v=%0b i=%0b d=%0d g=%h want v=0 i=1 d=0 g=00",
               rr_if.valid, rr_if.idle, rr_if.Dout, rr_if.gnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_hold();
    fp_if.en = 1'b1; fp_if.Din = 8'b1010_1010;
    tick();
    n_cmp++;
    if ({fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt} !== {1'b1, 1'b0, 3'd7, 8'h80}) begin
      n_err++;
      $display("FAIL fixed_grant: got v=%0b i=%0b d=%0d g=%h want v=1 i=0 d=7 g=80",
               fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt);
    end
    fp_if.Din = 8'h01; fp_if.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({fp_if.valid, fp_if.Dout, fp_if.gnt} !== {1'b1, 3'd7, 8'h80}) begin
        n_err++;
        $display("FAIL fixed_hold[%0d]: got v=%0b d=%0d g=%h want v=1 d=7 g=80",
                 c, fp_if.valid, fp_if.Dout, fp_if.gnt);
      end
    end
    fp_if.ack = 1'b1;
    tick();
    fp_if.ack = 1'b0; fp_if.Din = '0;
    n_cmp++;
    if ({fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
      n_err++;
      $display("FAIL fixed_release: got v=%0b i=%0b d=%0d g=%h want v=0 i=1 d=0 g=00",
               fp_if.valid, fp_if.idle, fp_if.Dout, fp_if.gnt);
    end
  endtask

  task automatic test_fixed_enable();
    fp_if.en = 1'b0; fp_if.Din = 8'h04;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({fp_if.valid, fp_if.idle, fp_if.gnt} !== {1'b0, 1'b1, 8'h00}) begin
        n_err++;
        $display("FAIL en_low[%0d]: got v=%0b i=%0b g=%h want v=0 i=1 g=00",
                 c, fp_if.valid, fp_if.idle, fp_if.gnt);
      end
    end
    fp_if.en = 1'b1;
    tick();
    n_cmp++;
    if ({fp_if.valid, fp_if.Dout, fp_if.gnt} !== {1'b1, 3'd2, 8'h04}) begin
      n_err++;
      $display("FAIL en_rise: got v=%0b d=%0d g=%h want v=1 d=2 g=04",
               fp_if.valid, fp_if.Dout, fp_if.gnt);
    end
    fp_if.ack = 1'b1;
    tick();
    fp_if.ack = 1'b0; fp_if.en = 1'b0; fp_if.Din = '0;
    n_cmp++;
    if ({fp_if.valid, fp_if.Dout} !== {1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL en_ack: got v=%0b d=%0d want v=0 d=0", fp_if.valid, fp_if.Dout);
    end
  endtask

  // Din=FF with immediate acks: grants walk 0..7 then wrap to 0.
  task automatic test_rr_sweep();
    rr_if.en = 1'b1; rr_if.Din = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      n_cmp++;
      if ({rr_if.valid, rr_if.Dout} !== {1'b1, 3'(g % 8)}) begin
        n_err++;
        $display("FAIL rr_sweep[%0d]: got v=%0b d=%0d want v=1 d=%0d",
                 g, rr_if.valid, rr_if.Dout, g % 8);
      end
      rr_if.ack = 1'b1;
      tick();
      rr_if.ack = 1'b0;
      n_cmp++;
      if ({rr_if.valid, rr_if.idle} !== 2'b01) begin
        n_err++;
        $display("FAIL rr_gap[%0d]: got v=%0b i=%0b want v=0 i=1",
                 g, rr_if.valid, rr_if.idle);
      end
    end
    rr_if.en = 1'b0; rr_if.Din = '0;
  endtask

  // ptr is 1 after the sweep; granting 5 moves it to 6.
  task automatic test_rr_wrap();
    rr_if.en = 1'b1; rr_if.Din = 8'h20;
    tick();
    n_cmp++;
    if (rr_if.Dout !== 3'd5) begin
      n_err++;
      $display("FAIL rr_to6: got d=%0d want d=5", rr_if.Dout);
    end
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0; rr_if.Din = 8'b0010_0010;
    tick();
    n_cmp++;
    if ({rr_if.valid, rr_if.Dout, rr_if.gnt} !== {1'b1, 3'd1, 8'h02}) begin
      n_err++;
      $display("FAIL rr_wrap: got v=%0b d=%0d g=%h want v=1 d=1 g=02",
               rr_if.valid, rr_if.Dout, rr_if.gnt);
    end
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0;
    tick();
    n_cmp++;
    if ({rr_if.valid, rr_if.Dout, rr_if.gnt} !== {1'b1, 3'd5, 8'h20}) begin
      n_err++;
      $display("FAIL rr_after_wrap: got v=%0b d=%0d g=%h want v=1 d=5 g=20",
               rr_if.valid, rr_if.Dout, rr_if.gnt);
    end
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0; rr_if.en = 1'b0; rr_if.Din = '0;
  endtask

  // ptr is 6 here; stray acks while idle must not move it.
  task automatic test_ack_idle();
    rr_if.en = 1'b1; rr_if.Din = '0; rr_if.ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({rr_if.valid, rr_if.idle} !== 2'b01) begin
        n_err++;
        $display("FAIL ack_idle[%0d]: got v=%0b i=%0b want v=0 i=1",
                 c, rr_if.valid, rr_if.idle);
      end
    end
    rr_if.ack = 1'b0; rr_if.Din = 8'h41;
    tick();
    n_cmp++;
    if ({rr_if.valid, rr_if.Dout} !== {1'b1, 3'd6}) begin
      n_err++;
      $display("FAIL ack_idle_ptr: got v=%0b d=%0d want v=1 d=6", rr_if.valid, rr_if.Dout);
    end
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0; rr_if.en = 1'b0; rr_if.Din = '0;
  endtask

  // ptr is 7; grant 5 moves it to 6 so a stale ptr would pick 6 after reset.
  task automatic test_reset_mid();
    rr_if.en = 1'b1; rr_if.Din = 8'h20;
    tick();
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0; rr_if.Din = 8'h08;
    tick();
    n_cmp++;
    if (rr_if.Dout !== 3'd3) begin
      n_err++;
      $display("FAIL mid_grant: got d=%0d want d=3", rr_if.Dout);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rr_if.valid, rr_if.idle, rr_if.Dout, rr_if.gnt} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset: got v=%0b i=%0b d=%0d g=%h want v=0 i=1 d=0 g=00",
               rr_if.valid, rr_if.idle, rr_if.Dout, rr_if.gnt);
    end
    rr_if.Din = 8'h48;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({rr_if.valid, rr_if.Dout, rr_if.gnt} !== {1'b1, 3'd3, 8'h08}) begin
      n_err++;
      $display("FAIL post_reset: got v=%0b d=%0d g=%h want v=1 d=3 g=08",
               rr_if.valid, rr_if.Dout, rr_if.gnt);
    end
    rr_if.ack = 1'b1;
    tick();
    rr_if.ack = 1'b0; rr_if.en = 1'b0; rr_if.Din = '0;
  endtask

  initial begin
    test_reset();
    test_fixed_hold();
    test_fixed_enable();
    test_rr_sweep();
    test_rr_wrap();
    test_ack_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
